// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int          PC_STEP_DEF = 2;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/acknowledge bus between fetch (master) and imem (slave).
interface fetch_if #(
    parameter int AW = 32
);
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [31:0]   rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush squashes to a NOP bubble, stall holds the
// entry exactly, load writes a new valid entry, otherwise a bubble is inserted.
module fetch_ifid_reg
    import fetch_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_stall,
    input  logic          i_load,
    input  logic [AW-1:0] i_pc,
    input  logic [31:0]   i_instr,
    output logic [AW-1:0] o_pc,
    output logic [31:0]   o_instr,
    output logic          o_valid
);

    logic [AW-1:0] r_pc;
    logic [31:0]   r_instr;
    logic          r_valid;

    // Entry update; PC is kept on flush/bubble so only valid/Instr change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_stall) begin
            r_pc    <= r_pc;
            r_instr <= r_instr;
            r_valid <= r_valid;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the imem req/ack bus and
// feeds decode through the IF/ID register. Optional performance counters are
// enabled with the FETCH_PERF_EN macro.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | request at fetch_pc outstanding
// DROP  | flushed while request pending; keep stale request until ack, discard data
// HOLD  | instruction captured while decode stalled; waiting to hand it over
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int          AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int          PC_STEP  = PC_STEP_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] branch_target,
    fetch_if.master       imem,
    output logic [AW-1:0] PC,
    output logic [31:0]   Instr,
    output logic          valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_squash
`endif
);

    fetch_state_t  r_state;
    fetch_state_t  w_next_state;
    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] w_next_pc;
    logic [AW-1:0] r_stale_addr;
    logic [31:0]   r_hold_instr;
    logic          w_capture_hold;
    logic          w_capture_stale;
    logic          w_load;
    logic [31:0]   w_load_instr;
    logic          w_req;
    logic [AW-1:0] w_addr;

    // State, fetch PC, stale request address and stall hold buffer.
    // The held instruction's PC is r_fetch_pc itself, which does not move in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= '0;
            r_hold_instr <= NOP_INSTR;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
            if (w_capture_stale) begin
                r_stale_addr <= r_fetch_pc;
            end
            if (w_capture_hold) begin
                r_hold_instr <= imem.rdata;
            end
        end
    end

    // Next-state, next fetch PC and bus outputs; flush redirects from any state.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_fetch_pc;
        w_capture_hold  = 1'b0;
        w_capture_stale = 1'b0;
        w_load          = 1'b0;
        w_load_instr    = imem.rdata;
        w_req           = 1'b0;
        w_addr          = r_fetch_pc;

        if (flush) begin
            w_next_pc = branch_target;
        end

        unique case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                w_req = 1'b1;
                if (flush) begin
                    w_next_state    = imem.ack ? FETCH : DROP;
                    w_capture_stale = ~imem.ack;
                end else if (stall) begin
                    if (imem.ack) begin
                        w_capture_hold = 1'b1;
                        w_next_state   = HOLD;
                    end
                end else if (imem.ack) begin
                    w_load    = 1'b1;
                    w_next_pc = r_fetch_pc + AW'(PC_STEP);
                end
            end
            HOLD: begin
                if (flush) begin
                    w_next_state = FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold_instr;
                    w_next_pc    = r_fetch_pc + AW'(PC_STEP);
                    w_next_state = FETCH;
                end
            end
            DROP: begin
                w_req  = 1'b1;
                w_addr = r_stale_addr;
                if (imem.ack) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign imem.req  = w_req;
    assign imem.addr = w_addr;

    fetch_ifid_reg #(
        .AW(AW)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_stall (stall),
        .i_load  (w_load),
        .i_pc    (r_fetch_pc),
        .i_instr (w_load_instr),
        .o_pc    (PC),
        .o_instr (Instr),
        .o_valid (valid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_squash;

    // Free-running wrap-around event counters; w_load is already gated by flush/stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
            r_perf_squash  <= '0;
        end else begin
            if (w_load && !flush && !stall) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (flush) begin
                r_perf_squash <= r_perf_squash + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
    assign perf_squash  = r_perf_squash;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: inputs and checks both on the falling edge.
module tb_instr_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_squash;
`endif

    int checks = 0;
    int passed = 0;

    fetch_if #(.AW(32)) imem ();

    instr_fetch_stage #(
        .AW(32),
        .RESET_PC(32'h0),
        .PC_STEP(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem          (imem.master),
        .PC            (PC),
        .Instr         (Instr),
        .valid         (valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
        .perf_squash   (perf_squash)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v);
        chk({tag, "_pc"}, PC, pc);
        chk({tag, "_instr"}, Instr, ins);
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_instr"}, Instr, NOP_INSTR);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    endtask

    task automatic chk_bus(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem.req}, {31'd0, r});
        if (r) chk({tag, "_addr"}, imem.addr, a);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        branch_target = '0;
        imem.ack = 1'b0;
        imem.rdata = '0;
        tick();
        tick();
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk_bus("rst", 1'b0, 32'h0);

        // IDLE -> FETCH one cycle after reset release
        reset = 1'b0;
        tick();
        chk_bus("first_req", 1'b1, 32'h0);

        // zero-wait memory: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            imem.ack = 1'b1;
            imem.rdata = 32'h1000_0000 + 32'(2 * i);
            tick();
            chk_ifid("zw", 32'(2 * i), 32'h1000_0000 + 32'(2 * i), 1'b1);
            chk_bus("zw", 1'b1, 32'(2 * i + 2));
        end

        // two-cycle latency: bubbles, stable address, one instr per 3 cycles
        for (int j = 0; j < 2; j++) begin
            imem.ack = 1'b0;
            tick();
            chk_bubble("lat_w1");
            chk_bus("lat_w1", 1'b1, 32'h8 + 32'(2 * j));
            tick();
            chk_bubble("lat_w2");
            chk_bus("lat_w2", 1'b1, 32'h8 + 32'(2 * j));
            imem.ack = 1'b1;
            imem.rdata = 32'h2000_0008 + 32'(2 * j);
            tick();
            chk_ifid("lat", 32'h8 + 32'(2 * j), 32'h2000_0008 + 32'(2 * j), 1'b1);
        end

        // stall for 3 cycles while ack arrives
        stall = 1'b1;
        imem.ack = 1'b1;
        imem.rdata = 32'hA5A5_0001;
        tick();
        chk_ifid("stall1", 32'hA, 32'h2000_000A, 1'b1);
        chk_bus("stall1", 1'b0, 32'h0);
        imem.ack = 1'b0;
        tick();
        chk_ifid("stall2", 32'hA, 32'h2000_000A, 1'b1);
        tick();
        chk_ifid("stall3", 32'hA, 32'h2000_000A, 1'b1);
        stall = 1'b0;
        tick();
        chk_ifid("release", 32'hC, 32'hA5A5_0001, 1'b1);
        chk_bus("release", 1'b1, 32'hE);

        // flush with ack: redirect to 0x8, data discarded
        flush = 1'b1;
        branch_target = 32'h8;
        imem.ack = 1'b1;
        imem.rdata = 32'hBADB_AD01;
        tick();
        chk_bubble("flush_ack");
        chk_bus("flush_ack", 1'b1, 32'h8);
        flush = 1'b0;
        imem.ack = 1'b0;
        tick();
        chk_bus("pend8", 1'b1, 32'h8);

        // flush to 0x100 while request to 0x8 outstanding -> DROP
        flush = 1'b1;
        branch_target = 32'h100;
        tick();
        chk_bubble("drop_enter");
        chk_bus("drop_enter", 1'b1, 32'h8);
        flush = 1'b0;
        tick();
        chk_bus("drop_hold", 1'b1, 32'h8);
        imem.ack = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        tick();
        chk_bubble("drop_discard");
        chk_bus("drop_discard", 1'b1, 32'h100);
        imem.rdata = 32'h3000_0100;
        tick();
        chk_ifid("target", 32'h100, 32'h3000_0100, 1'b1);
        chk_bus("target", 1'b1, 32'h102);

        // flush and stall in the same cycle
        flush = 1'b1;
        stall = 1'b1;
        branch_target = 32'h200;
        imem.rdata = 32'hBADB_AD02;
        tick();
        chk_bubble("flush_stall");
        chk_bus("flush_stall", 1'b1, 32'h200);
        flush = 1'b0;
        stall = 1'b0;
        imem.rdata = 32'h3000_0200;
        tick();
        chk_ifid("after_fs", 32'h200, 32'h3000_0200, 1'b1);

        // stall over a bubble keeps the bubble, then hands over the held word
        imem.ack = 1'b0;
        tick();
        chk_bubble("bub");
        stall = 1'b1;
        imem.ack = 1'b1;
        imem.rdata = 32'h0000_0044;
        tick();
        chk_bubble("bub_stall");
        stall = 1'b0;
        imem.ack = 1'b0;
        tick();
        chk_ifid("bub_rel", 32'h202, 32'h0000_0044, 1'b1);
        chk_bus("bub_rel", 1'b1, 32'h204);

        // PC wrap at all-ones
        flush = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        imem.ack = 1'b1;
        tick();
        chk_bus("wrap_redir", 1'b1, 32'hFFFF_FFFE);
        flush = 1'b0;
        imem.rdata = 32'h5000_0000;
        tick();
        chk_ifid("wrap", 32'hFFFF_FFFE, 32'h5000_0000, 1'b1);
        chk_bus("wrap", 1'b1, 32'h0);

        // reset in DROP with a late ack
        flush = 1'b1;
        branch_target = 32'h300;
        imem.ack = 1'b0;
        tick();
        chk_bus("pre_rst_drop", 1'b1, 32'h0);
        flush = 1'b0;
        reset = 1'b1;
        tick();
        chk_ifid("rst_drop", 32'h0, 32'h0, 1'b0);
        chk_bus("rst_drop", 1'b0, 32'h0);
        imem.ack = 1'b1;
        imem.rdata = 32'hBADB_AD03;
        tick();
        chk_ifid("rst_late", 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        tick();
        chk_bubble("late_ack_idle");
        chk_bus("late_ack_idle", 1'b1, 32'h0);
        imem.ack = 1'b0;
        tick();
        chk_bubble("post_rst_wait");
        imem.ack = 1'b1;
        imem.rdata = 32'h6000_0000;
        tick();
        chk_ifid("post_rst", 32'h0, 32'h6000_0000, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
